// File: rtl/hdmi_tx_timing_ctrl.sv
// Video timing controller for the HDMI TX pixel bus: register-programmed raster counters,
// sync/DE generation, ready/valid pixel intake and an Avalon-MM config/status port.
module hdmi_tx_timing_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [23:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        pix_sof,
   output logic [23:0] hdmi_d,
   output logic        hdmi_hs,
   output logic        hdmi_vs,
   output logic        hdmi_de,
   output logic        irq
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t      state;
   logic        irq_en, hs_pol, vs_pol;
   logic [11:0] r_h_active, r_h_total, r_h_sync_start, r_h_sync_end;
   logic [11:0] r_v_active, r_v_total, r_v_sync_start, r_v_sync_end;
   logic [11:0] s_h_active, s_h_total, s_h_sync_start, s_h_sync_end;
   logic [11:0] s_v_active, s_v_total, s_v_sync_start, s_v_sync_end;
   logic [11:0] h_cnt, v_cnt;
   logic        st_underflow, st_frame_pending, st_cfg_err;

   logic wr, wr_ctrl, w1c, run, h_last, v_last, frame_wrap;
   logic start_run, stop_run, load_req, cfg_ok, active, hs_raw, vs_raw;
   logic unused_bits;

   assign wr         = chipselect && !write_n;
   assign wr_ctrl    = wr && (address == 3'd0);
   assign w1c        = wr && (address == 3'd5);
   assign run        = (state == ST_RUN);
   assign h_last     = (h_cnt == s_h_total - 12'd1);
   assign v_last     = (v_cnt == s_v_total - 12'd1);
   assign frame_wrap = run && h_last && v_last;
   assign start_run  = !run && wr_ctrl && writedata[0];
   assign stop_run   = run && wr_ctrl && !writedata[0];
   assign load_req   = start_run || frame_wrap;
   // A degenerate raster (total not above active) would never blank; keep the old timing instead.
   assign cfg_ok     = (r_h_total > r_h_active) && (r_v_total > r_v_active);

   assign active     = (h_cnt < s_h_active) && (v_cnt < s_v_active);
   assign hs_raw     = (h_cnt >= s_h_sync_start) && (h_cnt < s_h_sync_end);
   assign vs_raw     = (v_cnt >= s_v_sync_start) && (v_cnt < s_v_sync_end);
   assign pix_ready  = run && active;
   assign pix_sof    = pix_ready && (h_cnt == 12'd0) && (v_cnt == 12'd0);
   assign irq        = irq_en && st_frame_pending;
   assign unused_bits = ^{writedata[31:28], writedata[15:12]};

   // Raster FSM, counters and working shadow timing set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         h_cnt          <= 12'd0;
         v_cnt          <= 12'd0;
         s_h_active     <= 12'd640;
         s_h_total      <= 12'd800;
         s_h_sync_start <= 12'd656;
         s_h_sync_end   <= 12'd752;
         s_v_active     <= 12'd480;
         s_v_total      <= 12'd525;
         s_v_sync_start <= 12'd490;
         s_v_sync_end   <= 12'd492;
      end else begin
         case (state)
            ST_IDLE: begin
               h_cnt <= 12'd0;
               v_cnt <= 12'd0;
               if (start_run) state <= ST_RUN;
            end
            ST_RUN: begin
               if (stop_run) begin
                  state <= ST_IDLE;
                  h_cnt <= 12'd0;
                  v_cnt <= 12'd0;
               end else if (h_last) begin
                  h_cnt <= 12'd0;
                  v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
               end else begin
                  h_cnt <= h_cnt + 12'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (load_req && cfg_ok) begin
            s_h_active     <= r_h_active;
            s_h_total      <= r_h_total;
            s_h_sync_start <= r_h_sync_start;
            s_h_sync_end   <= r_h_sync_end;
            s_v_active     <= r_v_active;
            s_v_total      <= r_v_total;
            s_v_sync_start <= r_v_sync_start;
            s_v_sync_end   <= r_v_sync_end;
         end
      end
   end

   // Software-visible registers and sticky status; a set beats a same-cycle W1C.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en           <= 1'b0;
         hs_pol           <= 1'b0;
         vs_pol           <= 1'b0;
         r_h_active       <= 12'd640;
         r_h_total        <= 12'd800;
         r_h_sync_start   <= 12'd656;
         r_h_sync_end     <= 12'd752;
         r_v_active       <= 12'd480;
         r_v_total        <= 12'd525;
         r_v_sync_start   <= 12'd490;
         r_v_sync_end     <= 12'd492;
         st_underflow     <= 1'b0;
         st_frame_pending <= 1'b0;
         st_cfg_err       <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            irq_en <= writedata[1];
            hs_pol <= writedata[2];
            vs_pol <= writedata[3];
         end
         if (wr && address == 3'd1) begin
            r_h_active <= writedata[11:0];
            r_h_total  <= writedata[27:16];
         end
         if (wr && address == 3'd2) begin
            r_h_sync_start <= writedata[11:0];
            r_h_sync_end   <= writedata[27:16];
         end
         if (wr && address == 3'd3) begin
            r_v_active <= writedata[11:0];
            r_v_total  <= writedata[27:16];
         end
         if (wr && address == 3'd4) begin
            r_v_sync_start <= writedata[11:0];
            r_v_sync_end   <= writedata[27:16];
         end
         st_underflow     <= (st_underflow && !(w1c && writedata[0])) || (pix_ready && !pix_valid);
         st_frame_pending <= (st_frame_pending && !(w1c && writedata[1])) || frame_wrap;
         st_cfg_err       <= (st_cfg_err && !(w1c && writedata[2])) || (load_req && !cfg_ok);
      end
   end

   // Pin drivers: one cycle behind the counter position that produced them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hdmi_d  <= 24'd0;
         hdmi_de <= 1'b0;
         hdmi_hs <= 1'b1;
         hdmi_vs <= 1'b1;
      end else begin
         hdmi_d  <= (pix_ready && pix_valid) ? pix_data : 24'd0;
         hdmi_de <= pix_ready;
         hdmi_hs <= run ? (hs_raw ~^ hs_pol) : !hs_pol;
         hdmi_vs <= run ? (vs_raw ~^ vs_pol) : !vs_pol;
      end
   end

   always_comb begin
      readdata = 32'd0;
      case (address)
         3'd0: readdata = {28'd0, vs_pol, hs_pol, irq_en, run};
         3'd1: readdata = {4'd0, r_h_total, 4'd0, r_h_active};
         3'd2: readdata = {4'd0, r_h_sync_end, 4'd0, r_h_sync_start};
         3'd3: readdata = {4'd0, r_v_total, 4'd0, r_v_active};
         3'd4: readdata = {4'd0, r_v_sync_end, 4'd0, r_v_sync_start};
         3'd5: readdata = {4'd0, v_cnt, 13'd0, st_cfg_err, st_frame_pending, st_underflow};
         default: readdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_hdmi_tx_timing_ctrl.sv
// Directed bench for hdmi_tx_timing_ctrl in a tiny 8x4 raster: pixel scoreboard plus
// per-cycle sync/DE/status checks against hand-derived raster positions.
module tb_hdmi_tx_timing_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [23:0] pix_data = 24'd0;
   logic        pix_valid = 1'b0;
   logic        pix_ready, pix_sof;
   logic [23:0] hdmi_d;
   logic        hdmi_hs, hdmi_vs, hdmi_de, irq;

   int checks = 0;
   int failures = 0;
   logic [23:0] exp_q[$];

   hdmi_tx_timing_ctrl dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
      .hdmi_d(hdmi_d), .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs), .hdmi_de(hdmi_de), .irq(irq)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Avalon write: called #1 after a rising edge, returns #1 after the write edge.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1; address = 3'd5;
   endtask

   // Pixel monitor: every DE cycle must carry the next expected pixel.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && hdmi_de === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pixel_unexpected: got 0x%06h with empty expected queue at %0t", hdmi_d, $time);
         end else begin
            chk("pixel_data", {8'd0, hdmi_d}, {8'd0, exp_q.pop_front()});
         end
      end
   end

   localparam logic [31:0] RST_REGS [0:7] = '{32'h0, 32'h0320_0280, 32'h02F0_0290,
      32'h020D_01E0, 32'h01EC_01EA, 32'h0, 32'h0, 32'h0};

   initial begin
      int m;
      logic en, act, val, wr_now, wrap, rise, hs_raw, vs_raw;
      logic [11:0] h, v;
      logic [23:0] dat;
      logic [2:0]  wa;
      logic [31:0] wd;
      logic p_de = 1'b0, p_hs = 1'b1, p_vs = 1'b1;
      logic e_uf = 1'b0, e_fp = 1'b0, e_cfg = 1'b0, bad = 1'b0;

      // reset-state checks
      repeat (2) @(posedge clk);
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         @(negedge clk);
         chk($sformatf("reset_reg%0d", a), readdata, RST_REGS[a]);
      end
      chk("reset_de", {31'd0, hdmi_de}, 32'd0);
      chk("reset_hs_vs", {30'd0, hdmi_hs, hdmi_vs}, 32'd3);
      chk("reset_ready_irq", {30'd0, pix_ready, irq}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // tiny mode: h 4/8 sync 5..7, v 2/4 sync 3..4
      wr(3'd1, 32'h0008_0004);
      wr(3'd2, 32'h0007_0005);
      wr(3'd3, 32'h0004_0002);
      wr(3'd4, 32'h0004_0003);
      wr(3'd0, 32'h0000_000F);

      // cycle k = 0 is the first RUN cycle
      for (int k = 0; k <= 150; k++) begin
         wr_now = 1'b0; wa = 3'd5; wd = 32'd0;
         if (k == 40)  begin wr_now = 1'b1; wa = 3'd5; wd = 32'h1; end
         if (k == 63)  begin wr_now = 1'b1; wa = 3'd5; wd = 32'h2; end
         if (k == 66)  begin wr_now = 1'b1; wa = 3'd5; wd = 32'h2; end
         if (k == 70)  begin wr_now = 1'b1; wa = 3'd1; wd = 32'h0004_0004; end
         if (k == 130) begin wr_now = 1'b1; wa = 3'd0; wd = 32'h0; end
         if (k == 133) begin wr_now = 1'b1; wa = 3'd1; wd = 32'h0008_0004; end
         if (k == 135) begin wr_now = 1'b1; wa = 3'd0; wd = 32'hF; end
         chipselect = wr_now; write_n = !wr_now; address = wa; writedata = wd;

         en = (k <= 130) || (k >= 136);
         m  = (k >= 136) ? k - 136 : k;
         h  = en ? 12'(m % 8) : 12'd0;
         v  = en ? 12'((m / 8) % 4) : 12'd0;
         act = en && (h < 12'd4) && (v < 12'd2);
         val = (k != 9);
         dat = 24'hA50000 + 24'(k);
         pix_valid = val; pix_data = dat;
         if (act) exp_q.push_back(val ? dat : 24'd0);

         @(negedge clk);
         chk($sformatf("pix_ready_k%0d", k), {31'd0, pix_ready}, {31'd0, act});
         chk($sformatf("pix_sof_k%0d", k), {31'd0, pix_sof}, {31'd0, act && h == 0 && v == 0});
         chk($sformatf("hdmi_de_k%0d", k), {31'd0, hdmi_de}, {31'd0, p_de});
         chk($sformatf("hdmi_hs_k%0d", k), {31'd0, hdmi_hs}, {31'd0, p_hs});
         chk($sformatf("hdmi_vs_k%0d", k), {31'd0, hdmi_vs}, {31'd0, p_vs});
         chk($sformatf("irq_k%0d", k), {31'd0, irq}, {31'd0, en && e_fp});
         if (wa == 3'd5)
            chk($sformatf("status_k%0d", k), readdata, {4'd0, v, 13'd0, e_cfg, e_fp, e_uf});

         hs_raw = (h >= 12'd5) && (h < 12'd7);
         vs_raw = (v == 12'd3);
         p_de = act;
         p_hs = en ? hs_raw : 1'b1;
         p_vs = en ? vs_raw : 1'b1;
         wrap = en && (h == 12'd7) && (v == 12'd3);
         rise = wr_now && (wa == 3'd0) && wd[0] && !en;
         if (wr_now && wa == 3'd5) begin
            if (wd[0]) e_uf = 1'b0;
            if (wd[1]) e_fp = 1'b0;
            if (wd[2]) e_cfg = 1'b0;
         end
         if (act && !val) e_uf = 1'b1;
         if (wrap) e_fp = 1'b1;
         if ((wrap || rise) && bad) e_cfg = 1'b1;
         if (wr_now && wa == 3'd1) bad = (wd[27:16] <= wd[11:0]);

         @(posedge clk); #1;
      end
      chipselect = 1'b0; write_n = 1'b1;
      chk("exp_q_drained", exp_q.size(), 32'd0);

      // asynchronous reset mid-frame
      address = 3'd1;
      #3 reset_n = 1'b0;
      #1;
      chk("midrst_de", {31'd0, hdmi_de}, 32'd0);
      chk("midrst_d", {8'd0, hdmi_d}, 32'd0);
      chk("midrst_hs_vs", {30'd0, hdmi_hs, hdmi_vs}, 32'd3);
      chk("midrst_irq_ready", {30'd0, irq, pix_ready}, 32'd0);
      chk("midrst_hcfg1", readdata, 32'h0320_0280);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      address = 3'd5;
      @(negedge clk);
      chk("post_rst_status", readdata, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hdmi_tx_timing_ctrl.md
# hdmi_tx_timing_ctrl

Video timing controller that sequences the 24-bit HDMI transmitter pixel bus. Generates horizontal/vertical counters, sync and data-enable strobes from software-programmed timing registers, pulls pixels from a ready/valid stream source, and drives the registered pixel/sync outputs to the HDMI TX pins. Sits between the Nios II Avalon-MM interconnect (configuration/status) and the pixel producer (frame reader or test-pattern source).

## Interface
- No parameters; all timing is register-programmed.
- clk  in  1  system/pixel clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  Avalon-MM word address
- chipselect  in  1  Avalon-MM select
- write_n  in  1  Avalon-MM write strobe, active low
- writedata  in  32  Avalon-MM write data
- readdata  out  32  Avalon-MM read data, combinational mux of address
- pix_data  in  24  RGB888 pixel from source
- pix_valid  in  1  pixel available
- pix_ready  out  1  controller consumes pixel this cycle
- pix_sof  out  1  high with pix_ready on first active pixel of a frame
- hdmi_d  out  24  pixel bus to HDMI TX
- hdmi_hs, hdmi_vs, hdmi_de  out  1 each  sync and data enable
- irq  out  1  frame-done interrupt, level

## Operation
- Registers (all writes when chipselect && !write_n; unused bits read 0):
  - 0 CTRL: [0] enable, [1] irq_en, [2] hs_pol, [3] vs_pol (1 = active high). Reset 0.
  - 1 HCFG1: [11:0] h_active (reset 640), [27:16] h_total (reset 800).
  - 2 HCFG2: [11:0] h_sync_start (reset 656), [27:16] h_sync_end (reset 752).
  - 3 VCFG1: [11:0] v_active (reset 480), [27:16] v_total (reset 525).
  - 4 VCFG2: [11:0] v_sync_start (reset 490), [27:16] v_sync_end (reset 492).
  - 5 STATUS: [0] underflow (sticky), [1] frame_pending, [2] cfg_err (sticky); write 1 clears each (W1C). [27:16] current v count, read-only.
  - 6–7: read 0, writes ignored.
- Shadow set: timing regs 1–4 copied to working shadow on enable 0→1 and at every frame wrap. Copy rejected if h_total <= h_active or v_total <= v_active: previous shadow kept, cfg_err set. Reset shadow = reset register values.
- States: IDLE (enable=0: h=v=0, outputs inactive, pix_ready=0) and RUN. IDLE→RUN cycle after enable written 1; RUN→IDLE immediately (next cycle) on enable written 0, counters cleared.
- RUN counters: h increments 0..h_total−1, wraps to 0 and increments v; v wraps 0 at v_total−1 (frame wrap). 12-bit unsigned compares.
- active = (h < h_active) && (v < v_active). pix_ready = RUN && active (combinational from counters). pix_sof = pix_ready && h==0 && v==0.
- hs_raw = h_sync_start <= h < h_sync_end; vs_raw likewise on v; outputs = raw XNOR pol (inactive level = !pol; in IDLE, inactive level).
- Active cycle with pix_valid=0: underflow set, hdmi_d driven 0 for that pixel, de still 1; no stall.
- frame_pending set on frame wrap; irq = irq_en && frame_pending. Set and W1C clear in same cycle: set wins.

## Timing
- Outputs hdmi_d/hs/vs/de registered: reflect counter position of previous cycle (1-cycle latency from pix_ready/pix_data sample).
- Reset values: hdmi_d=0, hdmi_de=0, hdmi_hs=hdmi_vs=1 (pol bits 0 → inactive high), pix_ready=0, pix_sof=0, irq=0, readdata per address of reset registers.
- Register writes take effect: CTRL next cycle; timing only at next shadow load.
- Reset asserted mid-frame: all state to reset values asynchronously; no partial line resumed.
- Frame length = h_total × v_total cycles exactly; no slip on underflow.

## Test plan
- Reset: assert reset_n=0 mid-RUN → hdmi_de=0, hdmi_d=0, hs=vs=1, irq=0, read addr1 = 0x0320_0280.
- Tiny mode: h 4/8 sync 5..7, v 2/4 sync 3..4, pol=11, enable, pix_valid=1 with incrementing data → de high 4 cycles per line on lines 0–1, hs high h=5,6 (seen one cycle later), vs high full line 3, frame = 32 cycles, data appears 1 cycle after pix_ready in order.
- Underflow: drop pix_valid for one active cycle → hdmi_d=0 that pixel, STATUS[0]=1; write 0x1 to STATUS → reads 0.
- IRQ: irq_en=1 → irq rises after frame wrap; W1C coincident with next wrap → stays 1.
- Bad config: write HCFG1 h_total=4, h_active=4 mid-frame → cfg_err=1 at wrap, timing unchanged (still 8-cycle lines).
- Disable mid-line: write CTRL=0 at h=2 → next cycle pix_ready=0, de=0 after one cycle; re-enable starts at h=v=0 with pix_sof=1.
